// File: rtl/led_pulse_stretch_pkg.sv
// led_pulse_stretch_pkg: state encoding and small helpers shared by the LED pulse stretcher
package led_pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pulse_stretch_if.sv
// led_pulse_stretch_if: event input and LED/status outputs of the pulse stretcher
interface led_pulse_stretch_if #(
    parameter int PEND_W = 4
);
    logic              trigger;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (
        output trigger,
        input  led,
        input  busy,
        input  pending,
        input  overflow
    );

    modport slave (
        input  trigger,
        output led,
        output busy,
        output pending,
        output overflow
    );
endinterface

// File: rtl/led_pulse_stretch.sv
// led_pulse_stretch: turns 1-cycle events into fixed ON/OFF LED blinks, queueing events that arrive mid-blink
module led_pulse_stretch
    import led_pulse_stretch_pkg::*;
#(
    parameter int CLK_FREQUENCY = 10_000_000,
    parameter int ON_HZ         = 8,
    parameter int OFF_HZ        = 8,
    parameter int PEND_W        = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    led_pulse_stretch_if.slave  bus
);

    localparam int ON_CYCLES  = CLK_FREQUENCY / ON_HZ;
    localparam int OFF_CYCLES = CLK_FREQUENCY / OFF_HZ;
    localparam int CNT_W      = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);

    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              led_q, led_d;
    logic              overflow_q, overflow_d;
    logic              off_last;

    // Next state: phase sequencing plus the saturating queue of deferred events
    always_comb begin
        state_d    = state_q;
        count_d    = count_q + CNT_W'(1);
        led_d      = led_q;
        pending_d  = pending_q;
        overflow_d = 1'b0;
        off_last   = (state_q == OFF) && (count_q == OFF_LAST);
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (bus.trigger) begin
                    state_d = ON;
                    led_d   = 1'b1;
                end
            end
            ON: begin
                if (count_q == ON_LAST) begin
                    state_d = OFF;
                    count_d = '0;
                    led_d   = 1'b0;
                end
            end
            OFF: begin
                if (off_last) begin
                    count_d = '0;
                    if (pending_q != '0) begin
                        state_d   = ON;
                        led_d     = 1'b1;
                        pending_d = pending_q - PEND_W'(1) + PEND_W'(bus.trigger);
                    end else if (bus.trigger) begin
                        state_d = ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                led_d   = 1'b0;
            end
        endcase
        // At the OFF terminal cycle the trigger is folded into the dequeue above
        if (bus.trigger && state_q != IDLE && !off_last) begin
            if (pending_q == PEND_MAX) overflow_d = 1'b1;
            else pending_d = pending_q + PEND_W'(1);
        end
    end

    // State registers; reset aborts any blink in progress and clears the queue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            pending_q  <= '0;
            led_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            led_q      <= led_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// tb_led_pulse_stretch: directed checks of blink timing, queueing, saturation and reset
module tb_led_pulse_stretch;

    logic clk;
    logic reset_n;
    int   vectors = 0;
    int   errors  = 0;

    led_pulse_stretch_if #(.PEND_W(2)) bus ();

    led_pulse_stretch #(
        .CLK_FREQUENCY (16),
        .ON_HZ         (4),
        .OFF_HZ        (8),
        .PEND_W        (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held with trigger toggling: every output stays zero
    task automatic test_reset();
        logic [4:0] got;
        reset_n     = 1'b0;
        bus.trigger = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.trigger = 1'(i % 2);
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            vectors++;
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL reset cyc %0d: got led/busy/pend/ovf=%b want %b", i, got, 5'b0);
            end
        end
        @(negedge clk);
        reset_n     = 1'b1;
        bus.trigger = 1'b0;
    endtask

    // One trigger from IDLE: 4 cycles on, 2 off, then idle
    task automatic test_single();
        string trig_s = "1000000";
        string led_s  = "1111000";
        string busy_s = "1111110";
        string pend_s = "0000000";
        string ovf_s  = "0000000";
        logic [4:0] got, exp;
        for (int i = 0; i < trig_s.len(); i++) begin
            bus.trigger = (trig_s[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_s[i] == "1", busy_s[i] == "1", 2'(pend_s[i] - 8'd48), ovf_s[i] == "1"};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
    endtask

    // Three extra events during the first blink are replayed as three more blinks
    task automatic test_queue();
        string trig_s = "1111000000000000000000000";
        string led_s  = "1111001111001111001111000";
        string busy_s = "1111111111111111111111110";
        string pend_s = "0123332222221111110000000";
        string ovf_s  = "0000000000000000000000000";
        logic [4:0] got, exp;
        for (int i = 0; i < trig_s.len(); i++) begin
            bus.trigger = (trig_s[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_s[i] == "1", busy_s[i] == "1", 2'(pend_s[i] - 8'd48), ovf_s[i] == "1"};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL queue cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
    endtask

    // Five extra events: queue saturates at 3, the last two are dropped with overflow pulses
    task automatic test_overflow();
        string trig_s = "1111110000000000000000000";
        string led_s  = "1111001111001111001111000";
        string busy_s = "1111111111111111111111110";
        string pend_s = "0123332222221111110000000";
        string ovf_s  = "0000110000000000000000000";
        logic [4:0] got, exp;
        for (int i = 0; i < trig_s.len(); i++) begin
            bus.trigger = (trig_s[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_s[i] == "1", busy_s[i] == "1", 2'(pend_s[i] - 8'd48), ovf_s[i] == "1"};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL overflow cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
    endtask

    // Trigger on the OFF terminal cycle: with an empty queue, then with a full one
    task automatic test_back_to_back();
        string trig_a = "1000001000000";
        string led_a  = "1111001111000";
        string busy_a = "1111111111110";
        string pend_a = "0000000000000";
        string trig_b = "1111001000000000000000000000000";
        string led_b  = "1111001111001111001111001111000";
        string busy_b = "1111111111111111111111111111110";
        string pend_b = "0123333333332222221111110000000";
        logic [4:0] got, exp;
        for (int i = 0; i < trig_a.len(); i++) begin
            bus.trigger = (trig_a[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_a[i] == "1", busy_a[i] == "1", 2'(pend_a[i] - 8'd48), 1'b0};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_empty cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
        for (int i = 0; i < trig_b.len(); i++) begin
            bus.trigger = (trig_b[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_b[i] == "1", busy_b[i] == "1", 2'(pend_b[i] - 8'd48), 1'b0};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_full cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
    endtask

    // Reset mid-blink drops led without a clock edge and clears the queue
    task automatic test_reset_mid_blink();
        string trig_s = "0001000000";
        string led_s  = "0001111000";
        string busy_s = "0001111110";
        logic [4:0] got, exp;
        for (int i = 0; i < 3; i++) begin
            bus.trigger = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.trigger = 1'b0;
        got = {bus.led, bus.busy, bus.pending, bus.overflow};
        vectors++;
        if (got !== 5'b11100) begin
            errors++;
            $display("FAIL pre_reset: got led/busy/pend/ovf=%b want %b", got, 5'b11100);
        end
        #2;
        reset_n = 1'b0;
        #1;
        got = {bus.led, bus.busy, bus.pending, bus.overflow};
        vectors++;
        if (got !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: got led/busy/pend/ovf=%b want %b", got, 5'b0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < trig_s.len(); i++) begin
            bus.trigger = (trig_s[i] == "1");
            @(posedge clk);
            #1;
            got = {bus.led, bus.busy, bus.pending, bus.overflow};
            exp = {led_s[i] == "1", busy_s[i] == "1", 2'b00, 1'b0};
            vectors++;
            if (got !== exp) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got led/busy/pend/ovf=%b want %b", i + 1, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_queue();
        test_overflow();
        test_back_to_back();
        test_reset_mid_blink();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
